// File: rtl/fdiv_if.sv
// ---------------------------------------------------------------------------
// fdiv_if -- handshake bundle for the sequential fp32 divider.
//
// Input side  : in_valid / in_ready with operands a (dividend), b (divisor).
// Output side : out_valid / out_ready with result and the four status flags
//               (flag_invalid, flag_dz, flag_ovf, flag_unf).
// Modports    : master = issue stage / bench, slave = divider.
// ---------------------------------------------------------------------------
interface fdiv_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_invalid;
  logic        flag_dz;
  logic        flag_ovf;
  logic        flag_unf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result,
           flag_invalid, flag_dz, flag_ovf, flag_unf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result,
           flag_invalid, flag_dz, flag_ovf, flag_unf
  );
endinterface

// File: rtl/fdiv_seq.sv
// ---------------------------------------------------------------------------
// fdiv_seq -- sequential IEEE-754 single-precision divider.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, aborts any operation in flight
//   bus    : fdiv_if.slave
//            in_valid/in_ready, a, b      operand handshake (ready only in IDLE)
//            out_valid/out_ready, result  result handshake, held until taken
//            flag_invalid/dz/ovf/unf      status, valid only with out_valid
//
// Operation: special operands (NaN, inf, zero; denormals flush to zero) are
// resolved in the accept cycle and reported one cycle later. Otherwise a
// restoring divider produces ITER quotient bits of {1,ma}/{1,mb}, one per
// cycle, followed by a single normalise/round/pack cycle.
//
// Build option: define FDIV_RNE_EN for round-to-nearest-even; without it the
// quotient is truncated. Latency is the same in both builds.
// ---------------------------------------------------------------------------
module fdiv_seq #(
  parameter int ITER = 26  // 24 significand + 1 normalisation + 1 guard bit
) (
  input  logic   clk,
  input  logic   rst_n,
  fdiv_if.slave  bus
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_PACK, S_DONE} state_t;

  state_t state, state_nxt;

  // -------------------------------------------------------------------------
  // Operand unpack and special-case classification (used in the accept cycle)
  // -------------------------------------------------------------------------
  logic        sign_in;
  logic [7:0]  a_exp, b_exp;
  logic [22:0] a_man, b_man;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign sign_in = bus.a[31] ^ bus.b[31];
  assign a_exp   = bus.a[30:23];
  assign b_exp   = bus.b[30:23];
  assign a_man   = bus.a[22:0];
  assign b_man   = bus.b[22:0];

  // exp==0 covers both true zero and denormals, which are flushed to zero.
  assign a_zero = (a_exp == 8'h00);
  assign b_zero = (b_exp == 8'h00);
  assign a_inf  = (a_exp == 8'hFF) && (a_man == 23'd0);
  assign b_inf  = (b_exp == 8'hFF) && (b_man == 23'd0);
  assign a_nan  = (a_exp == 8'hFF) && (a_man != 23'd0);
  assign b_nan  = (b_exp == 8'hFF) && (b_man != 23'd0);

  logic        spec_hit;
  logic [31:0] spec_res;
  logic        spec_inv, spec_dz;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    spec_hit = 1'b1;
    spec_res = 32'd0;
    spec_inv = 1'b0;
    spec_dz  = 1'b0;
    if (a_nan || b_nan) begin
      spec_res = QNAN;
      spec_inv = 1'b1;
    end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
      spec_res = QNAN;
      spec_inv = 1'b1;
    end else if (a_inf) begin
      spec_res = {sign_in, 8'hFF, 23'd0};
    end else if (b_inf) begin
      spec_res = {sign_in, 8'h00, 23'd0};
    end else if (b_zero) begin
      spec_res = {sign_in, 8'hFF, 23'd0};
      spec_dz  = 1'b1;
    end else if (a_zero) begin
      spec_res = {sign_in, 8'h00, 23'd0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  logic accept;
  assign accept = bus.in_valid && (state == S_IDLE);

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  logic               sign_q;
  logic [25:0]        rem_q;   // partial remainder, always < 2*divisor
  logic [23:0]        dvs_q;   // {1,mb}
  logic [25:0]        quo_q;   // quotient bits, MSB has weight 1
  logic [4:0]         cnt_q;
  logic signed [9:0]  exp_q;   // biased exponent before normalisation
  logic [31:0]        res_q;
  logic               inv_q, dz_q, ovf_q, unf_q;

  // One restoring step: subtract if it fits, then shift for the next bit.
  logic [25:0] trial;
  logic        q_bit;
  logic [25:0] rem_nxt;

  assign trial   = rem_q - {2'b00, dvs_q};
  assign q_bit   = (rem_q >= {2'b00, dvs_q});
  assign rem_nxt = q_bit ? {trial[24:0], 1'b0} : {rem_q[24:0], 1'b0};

  // -------------------------------------------------------------------------
  // Normalise, round and pack (consumed in PACK)
  // -------------------------------------------------------------------------
  logic               norm;
  logic [25:0]        quo_n;     // quotient with leading one at bit 25
  logic [23:0]        mant24;
  logic               grd, stk;
  logic               round_inc;
  logic [24:0]        mant_rnd;
  logic               rnd_carry;
  logic signed [9:0]  e_norm, e_fin;
  logic [31:0]        pack_res;
  logic               pack_ovf, pack_unf;

  assign norm   = quo_q[25];
  assign quo_n  = norm ? quo_q : {quo_q[24:0], 1'b0};
  assign mant24 = quo_n[25:2];
  assign grd    = quo_n[1];
  // Shifting the remainder left never drops a bit, so rem!=0 is exact.
  assign stk    = quo_n[0] | (rem_q != 26'd0);

`ifdef FDIV_RNE_EN
  assign round_inc = grd & (stk | mant24[0]);
`else
  logic unused_rnd;
  assign unused_rnd = grd ^ stk;
  assign round_inc  = 1'b0;
`endif

  assign mant_rnd  = {1'b0, mant24} + {24'd0, round_inc};
  assign rnd_carry = mant_rnd[24];
  assign e_norm    = exp_q - (norm ? 10'sd0 : 10'sd1);
  assign e_fin     = e_norm + (rnd_carry ? 10'sd1 : 10'sd0);

  always_comb begin
    pack_ovf = 1'b0;
    pack_unf = 1'b0;
    pack_res = {sign_q, e_fin[7:0], rnd_carry ? 23'd0 : mant_rnd[22:0]};
    if (e_fin >= 10'sd255) begin
      pack_res = {sign_q, 8'hFF, 23'd0};
      pack_ovf = 1'b1;
    end else if (e_fin <= 10'sd0) begin
      pack_res = {sign_q, 8'h00, 23'd0};
      pack_unf = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (accept) state_nxt = spec_hit ? S_DONE : S_DIV;
      S_DIV:  if (cnt_q == 5'(ITER - 1)) state_nxt = S_PACK;
      S_PACK: state_nxt = S_DONE;
      S_DONE: if (bus.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  logic in_ready_c, out_valid_c;

  always_comb begin
    in_ready_c  = (state == S_IDLE);
    out_valid_c = (state == S_DONE);
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = out_valid_c;
  assign bus.result       = res_q;
  assign bus.flag_invalid = inv_q;
  assign bus.flag_dz      = dz_q;
  assign bus.flag_ovf     = ovf_q;
  assign bus.flag_unf     = unf_q;

  // -------------------------------------------------------------------------
  // Datapath sequencing
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too, so an aborted divide leaves
    // no stale result or flag behind.
    if (!rst_n) begin
      sign_q <= 1'b0;
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      exp_q  <= '0;
      res_q  <= '0;
      inv_q  <= 1'b0;
      dz_q   <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            sign_q <= sign_in;
            if (spec_hit) begin
              res_q <= spec_res;
              inv_q <= spec_inv;
              dz_q  <= spec_dz;
            end else begin
              rem_q <= {2'b00, 1'b1, a_man};
              dvs_q <= {1'b1, b_man};
              quo_q <= '0;
              cnt_q <= '0;
              exp_q <= $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 10'sd127;
            end
          end
        end
        S_DIV: begin
          rem_q <= rem_nxt;
          quo_q <= {quo_q[24:0], q_bit};
          cnt_q <= cnt_q + 5'd1;
        end
        S_PACK: begin
          res_q <= pack_res;
          ovf_q <= pack_ovf;
          unf_q <= pack_unf;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            inv_q <= 1'b0;
            dz_q  <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_seq.sv
// ---------------------------------------------------------------------------
// tb_fdiv_seq -- self-checking bench for fdiv_seq.
//
// Directed vectors (exact division, 1/3, specials, overflow, underflow,
// backpressure, busy pulse, mid-divide reset) followed by random operands.
// Expected results come from an arithmetic reference model: the quotient is
// formed with integer division of the scaled significands, then normalised
// and rounded by the IEEE rules. Define FDIV_RNE_EN for both RTL and bench
// to check the rounding build.
// ---------------------------------------------------------------------------
module tb_fdiv_seq;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fdiv_if bus ();

  fdiv_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] flags_now();
    return {28'd0, bus.flag_invalid, bus.flag_dz, bus.flag_ovf, bus.flag_unf};
  endfunction

  // Reference model. flg = {invalid, dz, ovf, unf}; lat = cycle of out_valid.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic [31:0] flg,
                         output int lat);
    logic        s;
    int          ea, eb, e;
    logic        az, bz, ai, bi, an, bn;
    longint      x, d, q, r, mant;
    logic        g, st;
    s   = a[31] ^ b[31];
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    az  = (ea == 0);
    bz  = (eb == 0);
    ai  = (ea == 255) && (a[22:0] == 0);
    bi  = (eb == 255) && (b[22:0] == 0);
    an  = (ea == 255) && (a[22:0] != 0);
    bn  = (eb == 255) && (b[22:0] != 0);
    flg = 32'd0;
    lat = 1;
    if (an || bn)                  begin res = 32'h7FC00000; flg = 32'h8; end
    else if ((ai && bi) || (az && bz)) begin res = 32'h7FC00000; flg = 32'h8; end
    else if (ai)                   res = {s, 8'hFF, 23'd0};
    else if (bi)                   res = {s, 8'h00, 23'd0};
    else if (bz)                   begin res = {s, 8'hFF, 23'd0}; flg = 32'h4; end
    else if (az)                   res = {s, 8'h00, 23'd0};
    else begin
      lat = 28;
      x = longint'(a[22:0]) + (64'd1 << 23);
      d = longint'(b[22:0]) + (64'd1 << 23);
      q = (x << 25) / d;           // X/D scaled by 2^25, in [2^24, 2^26)
      r = (x << 25) % d;
      e = ea - eb + 127;
      if (q >= (64'd1 << 25)) begin
        mant = q / 4;
        g    = ((q / 2) % 2) != 0;
        st   = ((q % 2) != 0) || (r != 0);
      end else begin
        e    = e - 1;
        mant = q / 2;
        g    = (q % 2) != 0;
        st   = (r != 0);
      end
`ifdef FDIV_RNE_EN
      if (g && (st || (mant % 2) != 0)) mant = mant + 1;
`else
      if (g && st) mant = mant + 0;
`endif
      if (mant == (64'd1 << 24)) begin
        mant = 64'd1 << 23;
        e    = e + 1;
      end
      if (e >= 255)     begin res = {s, 8'hFF, 23'd0}; flg = 32'h2; end
      else if (e <= 0)  begin res = {s, 8'h00, 23'd0}; flg = 32'h1; end
      else              res = {s, 8'(e), mant[22:0]};
    end
  endtask

  // One complete divide. hold = cycles out_ready stays low in DONE;
  // poke > 0 drives a second in_valid pulse in that cycle of the operation.
  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input int hold, input int poke, input string tag);
    logic [31:0] er, ef;
    int          el, n, w;
    ref_div(a, b, er, ef, el);
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check({tag, " idle"}, {31'd0, bus.in_ready}, 32'd1);
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 60) begin
      if (n == poke) begin
        bus.in_valid = 1'b1;
        bus.a        = 32'h3F800000;
        bus.b        = 32'h3F800000;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n++;
    end
    check({tag, " latency"}, n, el);
    check({tag, " result"}, bus.result, er);
    check({tag, " flags"}, flags_now(), ef);
    check({tag, " busy in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold result"}, bus.result, er);
      check({tag, " hold valid"}, {31'd0, bus.out_valid}, 32'd1);
      check({tag, " hold in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " drop valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, " ready back"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, " flags cleared"}, flags_now(), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    rst_n         = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset result", bus.result, 32'd0);
    check("reset flags", flags_now(), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Main function and rounding
    run(32'h40C00000, 32'h40000000, 0, 0, "6/2");
    run(32'h3F800000, 32'h40400000, 0, 0, "1/3");
    run(32'hC1200000, 32'h40E00000, 0, 0, "-10/7");

    // Special cases
    run(32'h3F800000, 32'h00000000, 0, 0, "1/0");
    run(32'h00000000, 32'h00000000, 0, 0, "0/0");
    run(32'hFF800000, 32'h7F800000, 0, 0, "inf/inf");
    run(32'h80000000, 32'h3F800000, 0, 0, "-0/1");
    run(32'h7FC00001, 32'h3F800000, 0, 0, "nan/1");
    run(32'h7F800000, 32'hBF800000, 0, 0, "inf/-1");
    run(32'h3F800000, 32'hFF800000, 0, 0, "1/-inf");
    run(32'h00000001, 32'h3F800000, 0, 0, "denorm/1");
    run(32'h3F800000, 32'h00400000, 0, 0, "1/denorm");

    // Range limits
    run(32'h7F000000, 32'h3E800000, 0, 0, "ovf");
    run(32'h00800000, 32'h4B000000, 0, 0, "unf");
    run(32'h7F7FFFFF, 32'h3F7FFFFF, 0, 0, "max/0.99");

    // Backpressure and a busy pulse during DIV
    run(32'h40490FDB, 32'h402DF854, 10, 0, "backpressure");
    run(32'h41200000, 32'h40400000, 0, 5, "busy pulse");

    // Reset in cycle 10 of DIV
    bus.a        = 32'h40C00000;
    bus.b        = 32'h40000000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("abort result", bus.result, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      check("abort no emit", {31'd0, bus.out_valid}, 32'd0);
    end
    run(32'h40A00000, 32'h40000000, 0, 0, "after reset");

    // Random operands
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i < 16) begin
        ra[30:23] = 8'($urandom_range(100, 154));
        rb[30:23] = 8'($urandom_range(100, 154));
      end else begin
        ra[30:23] = 8'($urandom_range(1, 254));
        rb[30:23] = 8'($urandom_range(1, 254));
      end
      run(ra, rb, 0, 0, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fdiv_seq.md
Name: fdiv_seq

Overview:
- Sequential IEEE-754 single-precision divider; the inverse operation alongside the FMUL datapath in the FPU cluster.
- Unpacks both operands and classifies zero, infinity and NaN for the divide case: x/0, 0/0 and inf/inf.
- Computes the quotient mantissa with an iterative restoring divider, then normalises, rounds and packs the result.
- Uses a valid/ready handshake on both input and output so the VLIW issue stage can stall on it.

Parameters:
- ITER, 26, quotient bits generated: 24 significand bits, 1 normalisation bit and 1 guard bit; remainder gives sticky. Fixed; other values unsupported.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  high only in IDLE
- a  input  32  dividend, fp32
- b  input  32  divisor, fp32
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result
- result  output  32  quotient, fp32
- flag_invalid  output  1  NaN produced: NaN input, 0/0 or inf/inf
- flag_dz  output  1  finite nonzero divided by zero
- flag_ovf  output  1  exponent overflow, result is inf
- flag_unf  output  1  exponent underflow, result is zero

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; result=0; all flags=0; datapath registers cleared.
- Reset mid-operation aborts the operation; nothing is emitted.
- Accept: when in_valid && in_ready, capture a and b (cycle 0). Sign s = a[31]^b[31].
- Denormal inputs (exp=0, man!=0) are flushed to signed zero before classification.
- Special-case priority:
  1. Any NaN -> 0x7FC00000, invalid.
  2. inf/inf or 0/0 -> 0x7FC00000, invalid.
  3. inf/x -> {s,0xFF,0}.
  4. x/inf -> {s,0x00,0}.
  5. x/0 -> {s,0xFF,0}, dz.
  6. 0/x -> {s,0x00,0}.
- Special cases go IDLE->DONE; out_valid rises in cycle 1.
- Normal path, states IDLE->DIV->PACK->DONE:
  - DIV: ITER cycles, one quotient bit per cycle of {1,ma}/{1,mb}, restoring subtract on a 26-bit remainder.
  - Exponent: e = ea - eb + 127, computed in 10-bit signed.
  - PACK (1 cycle): if quotient MSB=0, shift left 1 and e=e-1; round; mantissa carry-out increments e.
  - Overflow: if e>=255 -> {s,0xFF,0}, ovf.
  - Underflow: if e<=0 -> {s,0x00,0}, unf (no subnormal output).
  - Normal-path out_valid rises in cycle ITER+2 = 28.
- DONE: result and flags held stable while out_valid=1 && out_ready=0.
  - On out_ready, the next state is IDLE and out_valid drops the following cycle.
  - in_ready=0 throughout DONE; no back-to-back overlap.
- Flags are valid only with out_valid; they are cleared on entering IDLE.
- in_valid while busy is ignored; the operands are not captured.

Optional Feature:
- Macro FDIV_RNE_EN.
- Defined: round-to-nearest-even using guard bit and sticky (sticky = remainder!=0); a rounding carry may overflow to inf and sets ovf.
- Undefined: truncation, guard and sticky discarded.
- Latency is identical either way.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0/2.0), out_ready=1 -> result 0x40400000 in cycle 28, no flags, in_ready back high in cycle 29.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB with FDIV_RNE_EN, 0x3EAAAAAA without.
- Specials: 0x3F800000/0x00000000 -> 0x7F800000 with dz. 0/0 -> 0x7FC00000 with invalid. 0xFF800000/0x7F800000 -> 0x7FC00000 with invalid. 0x80000000/0x3F800000 -> 0x80000000. All in cycle 1.
- Range: 0x7F000000/0x3E800000 -> 0x7F800000 with ovf. 0x00800000/0x4B000000 -> 0x00000000 with unf.
- Backpressure and busy: hold out_ready=0 for 10 cycles -> result stable, in_ready=0. A second in_valid pulse during DIV is not captured.
- Reset: assert rst_n=0 in cycle 10 of DIV -> out_valid=0 and in_ready=1 immediately. A new divide after release is correct.
